// File: rtl/button_pkg.sv
// Shared constants for the button path: FSM state encoding and 50 MHz timing defaults.
package button_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_LONG  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_PRESS = ST_PRESS,
        S_LONG  = ST_LONG
    } btn_state_e;

    // 1 s to long press, 200 ms between repeats at a 50 MHz clock
    localparam int CLK_HZ            = 50_000_000;
    localparam int DEF_LONG_CYCLES   = CLK_HZ;
    localparam int DEF_REPEAT_CYCLES = CLK_HZ / 5;
    localparam int DEF_CNT_W         = 26;

endpackage

// File: rtl/btn_edge_detect.sv
// Registers the debounced button level and flags its rising and falling edges.
module btn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn_clean,
    output logic rise,
    output logic fall
);

    logic btn_d_q;
    logic btn_d_d;

    always_comb begin
        btn_d_d = btn_clean;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_d_q <= 1'b0;
        end else begin
            btn_d_q <= btn_d_d;
        end
    end

    assign rise = btn_clean & ~btn_d_q;
    assign fall = ~btn_clean & btn_d_q;

endmodule

// File: rtl/button_press_decoder.sv
// Turns the debounced button level into press/release/short/long/repeat pulses.
// Auto-repeat while long-held is enabled by defining BTN_AUTOREPEAT_EN.
module button_press_decoder
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic rise;
    logic fall;

    btn_edge_detect u_edge (
        .clk       (clk),
        .reset     (reset),
        .btn_clean (btn_clean),
        .rise      (rise),
        .fall      (fall)
    );

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic press_q, press_d;
    logic release_q, release_d;
    logic short_q, short_d;
    logic long_q, long_d;
    logic repeat_q, repeat_d;
    logic held_q, held_d;

    // Outside IDLE the button was high on the previous edge, so fall == release.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESS;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            S_PRESS: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    short_d   = 1'b1;
                    release_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = S_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LONG: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                end else if (AUTOREPEAT) begin
                    if (cnt_q == REP_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d != S_IDLE) | release_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule
